// File: rtl/iob_pfsm_timed_if.sv
// IOb-native CSR bus bundle for iob_pfsm_timed: request (valid/addr/wdata/wstrb) and response (ready/rvalid/rdata).
// wstrb nonzero marks a write, zero marks a read; ready is always high on the slave side.
interface iob_pfsm_timed_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic                valid;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                ready;
    logic                rvalid;
    logic [DATA_W-1:0]   rdata;

    modport master (
        output valid, addr, wdata, wstrb,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  valid, addr, wdata, wstrb,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/iob_pfsm_timed.sv
// Programmable FSM: LUT[{state,inputs}] -> {hold, next_state, outputs}, with a dwell of hold cycles after each transition.
// Latency: RUN write at t -> EVAL at t+1 -> outputs at t+2; CSR reads return one cycle after the request, ready is always 1.
// Optional IOB_PFSM_TIMED_STEP_EN: CTRL bit2 STEP performs one EVAL plus its HOLD from IDLE.
module iob_pfsm_timed #(
    parameter int STATE_W  = 2,
    parameter int INPUT_W  = 1,
    parameter int OUTPUT_W = 1,
    parameter int CNT_W    = 16,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 12
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    input  logic                 cke_i,
    iob_pfsm_timed_if.slave      iob,
    input  logic [INPUT_W-1:0]   input_ports,
    output logic [OUTPUT_W-1:0]  output_ports
);
    localparam int IDX_W   = STATE_W + INPUT_W;
    localparam int DEPTH   = 1 << IDX_W;
    localparam int ENTRY_W = OUTPUT_W + STATE_W + CNT_W;
    localparam int WORD_W  = ADDR_W - 2;
    localparam logic [WORD_W-1:0] LUT_BASE = WORD_W'(64);

    if (ENTRY_W > DATA_W) begin : g_bad_entry
        $error("iob_pfsm_timed: CNT_W+STATE_W+OUTPUT_W exceeds DATA_W");
    end
    if ((64'd1 << ADDR_W) < 64'(256 + 4 * DEPTH)) begin : g_bad_addr
        $error("iob_pfsm_timed: ADDR_W cannot reach the LUT window");
    end

    typedef enum logic [1:0] {IDLE, EVAL, HOLD} ctrl_t;

    ctrl_t                ctrl_st, ctrl_nxt;
    logic                 run, run_nxt;
    logic                 step_req, step_act;
    logic [STATE_W-1:0]   fsm_state;
    logic [CNT_W-1:0]     hold_cnt;
    logic [31:0]          trans_cnt;
    logic [ENTRY_W-1:0]   lut [DEPTH];

    logic [WORD_W-1:0]    word, lut_off;
    logic                 wr, rd, sel_ctrl, sel_status, sel_cnt, sel_lut;
    logic                 ctrl_wr, soft_rst, eval_en, hold_dec;
    logic [IDX_W-1:0]     lut_idx;
    logic [ENTRY_W-1:0]   entry;
    logic [OUTPUT_W-1:0]  ent_out;
    logic [STATE_W-1:0]   ent_nxt;
    logic [CNT_W-1:0]     ent_hold;
    logic [DATA_W-1:0]    rd_val;
    logic                 unused_bits;

    assign iob.ready   = 1'b1;
    assign unused_bits = ^{iob.addr[1:0], iob.wdata};

    assign word       = iob.addr[ADDR_W-1:2];
    assign lut_off    = word - LUT_BASE;
    assign lut_idx    = lut_off[IDX_W-1:0];
    assign wr         = iob.valid && (iob.wstrb != '0);
    assign rd         = iob.valid && (iob.wstrb == '0);
    assign sel_ctrl   = (word == WORD_W'(0));
    assign sel_status = (word == WORD_W'(1));
    assign sel_cnt    = (word == WORD_W'(2));
    assign sel_lut    = (word >= LUT_BASE) && (lut_off < WORD_W'(DEPTH));

    // SOFTRESET dominates RUN carried in the same write
    assign ctrl_wr  = wr && sel_ctrl;
    assign soft_rst = ctrl_wr && iob.wdata[1];
    assign run_nxt  = soft_rst ? 1'b0 : (ctrl_wr ? iob.wdata[0] : run);

    assign entry    = lut[{fsm_state, input_ports}];
    assign ent_out  = entry[OUTPUT_W-1:0];
    assign ent_nxt  = entry[OUTPUT_W +: STATE_W];
    assign ent_hold = entry[OUTPUT_W+STATE_W +: CNT_W];

`ifdef IOB_PFSM_TIMED_STEP_EN
    assign step_req = ctrl_wr && iob.wdata[2] && !soft_rst && !run_nxt && (ctrl_st == IDLE);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            step_act <= 1'b0;
        end else if (cke_i) begin
            step_act <= (ctrl_nxt != IDLE) && !run_nxt && (step_act || step_req);
        end
    end
`else
    assign step_req = 1'b0;
    assign step_act = 1'b0;
`endif

    // An EVAL cycle commits even when RUN is cleared in that same cycle
    assign eval_en  = (ctrl_st == EVAL) && !soft_rst;
    assign hold_dec = (ctrl_st == HOLD) && !soft_rst && (run_nxt || step_act);

    always_comb begin
        ctrl_nxt = IDLE;
        if (soft_rst) begin
            ctrl_nxt = IDLE;
        end else if (run_nxt || step_act) begin
            case (ctrl_st)
                IDLE:    ctrl_nxt = run_nxt ? EVAL : IDLE;
                EVAL:    ctrl_nxt = (ent_hold != '0) ? HOLD : (run_nxt ? EVAL : IDLE);
                HOLD:    ctrl_nxt = (hold_cnt == CNT_W'(1)) ? (run_nxt ? EVAL : IDLE) : HOLD;
                default: ctrl_nxt = IDLE;
            endcase
        end else if (step_req) begin
            ctrl_nxt = EVAL;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            ctrl_st      <= IDLE;
            run          <= 1'b0;
            fsm_state    <= '0;
            output_ports <= '0;
            hold_cnt     <= '0;
            trans_cnt    <= '0;
        end else if (cke_i) begin
            ctrl_st <= ctrl_nxt;
            run     <= run_nxt;
            if (soft_rst) begin
                fsm_state    <= '0;
                output_ports <= '0;
                hold_cnt     <= '0;
                trans_cnt    <= '0;
            end else if (eval_en) begin
                fsm_state    <= ent_nxt;
                output_ports <= ent_out;
                hold_cnt     <= ent_hold;
                trans_cnt    <= trans_cnt + 32'd1;
            end else if (hold_dec) begin
                hold_cnt <= hold_cnt - CNT_W'(1);
            end
        end
    end

    // LUT has no reset; writes land only while the controller is IDLE
    always_ff @(posedge clk_i) begin
        if (cke_i && wr && sel_lut && (ctrl_st == IDLE)) begin
            lut[lut_idx] <= iob.wdata[ENTRY_W-1:0];
        end
    end

    always_comb begin
        rd_val = '0;
        if (sel_ctrl) begin
            rd_val[0] = run;
        end else if (sel_status) begin
            rd_val[STATE_W-1:0] = fsm_state;
            rd_val[16]          = (ctrl_st != IDLE);
        end else if (sel_cnt) begin
            rd_val = DATA_W'(trans_cnt);
        end else if (sel_lut) begin
            rd_val = DATA_W'(lut[lut_idx]);
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            iob.rvalid <= 1'b0;
            iob.rdata  <= '0;
        end else if (cke_i) begin
            iob.rvalid <= rd;
            if (rd) begin
                iob.rdata <= rd_val;
            end
        end
    end
endmodule

// File: tb/tb_iob_pfsm_timed.sv
// Bench for iob_pfsm_timed: directed scenarios plus randomized LUT runs checked against a transition-level model.
module tb_iob_pfsm_timed;
    localparam int DEPTH = 8;
    localparam logic [11:0] A_CTRL = 12'h000;
    localparam logic [11:0] A_STAT = 12'h004;
    localparam logic [11:0] A_CNT  = 12'h008;
    localparam logic [11:0] A_LUT  = 12'h100;

    logic       clk  = 1'b0;
    logic       arst = 1'b1;
    logic       cke  = 1'b1;
    logic [0:0] in_p = 1'b0;
    logic [0:0] out_p;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    logic [31:0] m_lut [DEPTH];
    int          m_state = 0;
    int          m_out   = 0;
    int          m_in    = 0;
    int unsigned m_trans = 0;
    bit          m_run   = 1'b0;
    int          m_next  = 0;

    iob_pfsm_timed_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    iob_pfsm_timed #(
        .STATE_W(2), .INPUT_W(1), .OUTPUT_W(1), .CNT_W(16), .DATA_W(32), .ADDR_W(12)
    ) dut (
        .clk_i       (clk),
        .arst_i      (arst),
        .cke_i       (cke),
        .iob         (bus),
        .input_ports (in_p),
        .output_ports(out_p)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Model works per transition: each EVAL sits at m_next, the next one hold+1 cycles later
    function automatic logic [31:0] mk_entry(input int nxt, input int out, input int hold);
        return (32'(hold) << 3) | (32'(nxt) << 1) | 32'(out);
    endfunction

    function automatic void model_eval();
        logic [31:0] e;
        e       = m_lut[m_state * 2 + m_in];
        m_out   = int'(e[0]);
        m_state = int'(e[2:1]);
        m_trans = m_trans + 1;
        m_next  = m_next + int'(e[18:3]) + 1;
    endfunction

    function automatic void model_to(input int c);
        while (m_run && m_next < c) model_eval();
    endfunction

    function automatic void model_softreset();
        m_state = 0; m_out = 0; m_trans = 0; m_run = 1'b0;
    endfunction

    task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
        bus.valid = 1'b1; bus.addr = a; bus.wdata = d; bus.wstrb = 4'hF;
        @(posedge clk); #1;
        bus.valid = 1'b0; bus.wstrb = 4'h0;
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [31:0] d, output logic rv);
        bus.valid = 1'b1; bus.addr = a; bus.wstrb = 4'h0;
        @(posedge clk); #1;
        bus.valid = 1'b0;
        d  = bus.rdata;
        rv = bus.rvalid;
    endtask

    task automatic lut_prog(input int i, input logic [31:0] v);
        bus_write(A_LUT + 12'(4 * i), v);
        m_lut[i] = v & 32'h0007_FFFF;
    endtask

    task automatic start_run();
        int t;
        t = cyc;
        bus_write(A_CTRL, 32'h1);
        m_run = 1'b1; m_next = t + 1;
    endtask

    task automatic stop_run();
        int t;
        t = cyc;
        bus_write(A_CTRL, 32'h0);
        model_to(t + 1);
        m_run = 1'b0;
    endtask

    task automatic soft_reset();
        bus_write(A_CTRL, 32'h2);
        model_softreset();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        rv;
        logic [11:0] addrs [5] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h120};
        bus.valid = 1'b0; bus.addr = '0; bus.wdata = '0; bus.wstrb = '0;
        arst = 1'b1;
        repeat (3) @(posedge clk);
        #1 arst = 1'b0;
        checks++; if (out_p !== 1'b0) $display("FAIL reset_out: got %b expected 0", out_p);
        if (out_p !== 1'b0) errors++;
        checks++;
        if (bus.rvalid !== 1'b0 || bus.rdata !== 32'h0 || bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_bus: rvalid=%b rdata=%h ready=%b expected 0/0/1", bus.rvalid, bus.rdata, bus.ready);
        end
        for (int i = 0; i < 5; i++) begin
            bus_read(addrs[i], d, rv);
            checks++;
            if (rv !== 1'b1 || d !== 32'h0) begin
                errors++;
                $display("FAIL reset_read[%h]: rvalid=%b data=%h expected 1/0", addrs[i], rv, d);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (bus.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rvalid_pulse: got %b expected 0", bus.rvalid);
        end
    endtask

    task automatic test_ring();
        logic [31:0] d;
        logic        rv;
        int          a;
        soft_reset();
        in_p = 1'b0; m_in = 0;
        for (int i = 0; i < DEPTH; i++) lut_prog(i, mk_entry(((i >> 1) + 1) % 4, (i >> 1) & 1, 0));
        start_run();
        for (int k = 0; k < 5; k++) begin
            model_to(cyc);
            checks++;
            if (out_p !== m_out[0]) begin
                errors++; $display("FAIL ring_out[%0d]: got %b expected %b", k, out_p, m_out[0]);
            end
            bus_read(A_STAT, d, rv);
            checks++;
            if (d !== (32'h10000 | 32'(k % 4))) begin
                errors++; $display("FAIL ring_state[%0d]: got %h expected %h", k, d, 32'h10000 | 32'(k % 4));
            end
        end
        bus_read(A_CNT, d, rv);
        checks++;
        if (d !== 32'd5) begin
            errors++; $display("FAIL ring_trans: got %0d expected 5", d);
        end
        a = cyc;
        model_to(a);
        cke = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            checks++;
            if (out_p !== m_out[0]) begin
                errors++; $display("FAIL cke_freeze: got %b expected %b", out_p, m_out[0]);
            end
        end
        cke = 1'b1;
        m_next = m_next + 4;
        repeat (3) begin
            model_to(cyc);
            bus_read(A_STAT, d, rv);
            checks++;
            if (d !== (32'h10000 | 32'(m_state))) begin
                errors++; $display("FAIL cke_resume_state: got %h expected %h", d, 32'h10000 | 32'(m_state));
            end
        end
        stop_run();
        bus_read(A_STAT, d, rv);
        checks++;
        if (d !== 32'(m_state)) begin
            errors++; $display("FAIL ring_stop_status: got %h expected %h", d, 32'(m_state));
        end
    endtask

    task automatic test_hold();
        logic [31:0] d;
        logic        rv;
        int          t0, ones;
        logic        o1, o2;
        soft_reset();
        in_p = 1'b0; m_in = 0;
        lut_prog(0, mk_entry(1, 1, 3));
        lut_prog(1, mk_entry(1, 1, 3));
        for (int i = 2; i < DEPTH; i++) lut_prog(i, mk_entry(0, 0, 0));
        t0 = cyc;
        start_run();
        ones = 0;
        for (int k = 1; k <= 12; k++) begin
            model_to(cyc);
            checks++;
            if (out_p !== m_out[0]) begin
                errors++; $display("FAIL hold_out[%0d]: got %b expected %b", k, out_p, m_out[0]);
            end
            if (k >= 2 && k <= 6) ones = ones + int'(out_p);
            @(posedge clk); #1;
        end
        checks++;
        if (ones !== 4) begin
            errors++; $display("FAIL hold_dwell: outputs high %0d cycles, expected 4", ones);
        end
        stop_run();

        soft_reset();
        lut_prog(0, mk_entry(1, 1, 16'hFFFF));
        t0 = cyc;
        start_run();
        repeat (65535) @(posedge clk);
        #1;
        bus_read(A_CNT, d, rv);
        o1 = out_p[0];
        checks++;
        if (d !== 32'd1 || o1 !== 1'b1) begin
            errors++; $display("FAIL hold_max_mid: trans=%0d out=%b expected 1/1", d, o1);
        end
        bus_read(A_CNT, d, rv);
        o2 = out_p[0];
        checks++;
        if (d !== 32'd1 || o2 !== 1'b0) begin
            errors++; $display("FAIL hold_max_edge: trans=%0d out=%b expected 1/0", d, o2);
        end
        bus_read(A_CNT, d, rv);
        checks++;
        if (d !== 32'd2 || cyc !== t0 + 65539) begin
            errors++; $display("FAIL hold_max_period: trans=%0d expected 2", d);
        end
        stop_run();
    endtask

    task automatic test_lut_lock();
        logic [31:0] d, v2;
        logic        rv;
        soft_reset();
        in_p = 1'b0; m_in = 0;
        for (int i = 0; i < DEPTH; i++) lut_prog(i, mk_entry(((i >> 1) + 1) % 4, 1, 1));
        v2 = m_lut[2];
        start_run();
        bus_write(A_LUT + 12'h8, 32'h0000_0ABC);
        bus_read(A_LUT + 12'h8, d, rv);
        checks++;
        if (d !== v2) begin
            errors++; $display("FAIL lut_lock: got %h expected %h", d, v2);
        end
        bus_read(A_STAT, d, rv);
        checks++;
        if (d[16] !== 1'b1) begin
            errors++; $display("FAIL running_high: got %b expected 1", d[16]);
        end
        stop_run();
        bus_read(A_STAT, d, rv);
        checks++;
        if (d !== 32'(m_state)) begin
            errors++; $display("FAIL running_drop: got %h expected %h", d, 32'(m_state));
        end
        lut_prog(2, 32'h0000_0ABC);
        bus_read(A_LUT + 12'h8, d, rv);
        checks++;
        if (d !== 32'h0000_0ABC) begin
            errors++; $display("FAIL lut_write_idle: got %h expected 00000abc", d);
        end
        lut_prog(3, 32'hFFFF_FFFF);
        bus_read(A_LUT + 12'hC, d, rv);
        checks++;
        if (d !== 32'h0007_FFFF) begin
            errors++; $display("FAIL lut_width: got %h expected 0007ffff", d);
        end
    endtask

    task automatic test_softreset();
        logic [31:0] d;
        logic        rv;
        logic [11:0] addrs [3] = '{A_STAT, A_CNT, A_CTRL};
        soft_reset();
        in_p = 1'b0; m_in = 0;
        lut_prog(0, mk_entry(2, 1, 10));
        lut_prog(4, mk_entry(0, 0, 0));
        start_run();
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (out_p !== 1'b1) begin
            errors++; $display("FAIL sr_pre_out: got %b expected 1", out_p);
        end
        bus_write(A_CTRL, 32'h3);
        model_softreset();
        checks++;
        if (out_p !== 1'b0) begin
            errors++; $display("FAIL sr_out: got %b expected 0", out_p);
        end
        for (int i = 0; i < 3; i++) begin
            bus_read(addrs[i], d, rv);
            checks++;
            if (d !== 32'h0) begin
                errors++; $display("FAIL sr_reg[%h]: got %h expected 0", addrs[i], d);
            end
        end
        bus_read(A_LUT, d, rv);
        checks++;
        if (d !== mk_entry(2, 1, 10)) begin
            errors++; $display("FAIL sr_lut_kept: got %h expected %h", d, mk_entry(2, 1, 10));
        end
        repeat (3) @(posedge clk);
        #1;
        bus_read(A_STAT, d, rv);
        checks++;
        if (d !== 32'h0 || out_p !== 1'b0) begin
            errors++; $display("FAIL sr_stays_idle: status=%h out=%b expected 0/0", d, out_p);
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic        rv;
        int          n;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < DEPTH; i++)
                lut_prog(i, ($urandom & 32'hFFF8_0007) | (32'($urandom_range(0, 3)) << 3));
            in_p = 1'($urandom_range(0, 1));
            m_in = int'(in_p);
            start_run();
            n = $urandom_range(8, 30);
            for (int k = 0; k < n; k++) begin
                model_to(cyc);
                checks++;
                if (out_p !== m_out[0]) begin
                    errors++; $display("FAIL rand_out[%0d.%0d]: got %b expected %b", r, k, out_p, m_out[0]);
                end
                bus_read(A_STAT, d, rv);
                checks++;
                if (d !== (32'h10000 | 32'(m_state))) begin
                    errors++; $display("FAIL rand_state[%0d.%0d]: got %h expected %h", r, k, d, 32'h10000 | 32'(m_state));
                end
            end
            stop_run();
            bus_read(A_CNT, d, rv);
            checks++;
            if (d !== 32'(m_trans)) begin
                errors++; $display("FAIL rand_trans[%0d]: got %0d expected %0d", r, d, m_trans);
            end
        end
    endtask

    task automatic test_step();
        logic [31:0] d;
        logic        rv;
`ifdef IOB_PFSM_TIMED_STEP_EN
        logic [31:0] exp_st [4] = '{32'h10000, 32'h10001, 32'h10001, 32'h00001};
        soft_reset();
        in_p = 1'b0; m_in = 0;
        lut_prog(0, mk_entry(1, 1, 2));
        lut_prog(2, mk_entry(2, 0, 0));
        bus_write(A_CTRL, 32'h4);
        for (int k = 0; k < 4; k++) begin
            bus_read(A_STAT, d, rv);
            checks++;
            if (d !== exp_st[k]) begin
                errors++; $display("FAIL step_status[%0d]: got %h expected %h", k, d, exp_st[k]);
            end
        end
        model_eval();
        bus_read(A_CNT, d, rv);
        checks++;
        if (d !== 32'd1 || out_p !== 1'b1) begin
            errors++; $display("FAIL step_once: trans=%0d out=%b expected 1/1", d, out_p);
        end
        start_run();
        repeat (3) @(posedge clk);
        #1;
        bus_write(A_CTRL, 32'h5);
        repeat (3) @(posedge clk);
        #1;
        stop_run();
        bus_read(A_CNT, d, rv);
        checks++;
        if (d !== 32'(m_trans)) begin
            errors++; $display("FAIL step_while_run: trans=%0d expected %0d", d, m_trans);
        end
`else
        bus_write(A_CTRL, 32'h4);
        repeat (3) @(posedge clk);
        #1;
        bus_read(A_STAT, d, rv);
        checks++;
        if (d !== 32'(m_state)) begin
            errors++; $display("FAIL nostep_status: got %h expected %h", d, 32'(m_state));
        end
        bus_read(A_CNT, d, rv);
        checks++;
        if (d !== 32'(m_trans)) begin
            errors++; $display("FAIL nostep_trans: got %0d expected %0d", d, m_trans);
        end
        bus_read(A_CTRL, d, rv);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL nostep_ctrl: got %h expected 0", d);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_ring();
        test_hold();
        test_lut_lock();
        test_softreset();
        test_random();
        test_step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
